cordic_arbiter: RTL and testbench

Round-robin scheduler that shares one pipelined CORDIC sin/cos core between two phase requesters. It accepts one phase per cycle from either requester over a valid/ready handshake and issues it to the core. It tags each issued phase with its requester ID in a LAT-deep tag pipeline and routes each returning sin/cos result back to the requester that issued it. It sits between the phase sources and the CORDIC core in the CORDIC test top.

---
 rtl/cordic_arbiter_if.sv | 34 +++
 rtl/cordic_arbiter.sv | 58 +++++
 tb/tb_cordic_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_arbiter_if.sv
// cordic_arbiter_if: requester handshakes, core issue/return and response bus of the CORDIC arbiter.
interface cordic_arbiter_if #(
    parameter int PHASE_W = 32,
    parameter int DATA_W  = 32
);
    logic               en;
    logic               req0_valid;
    logic               req0_ready;
    logic [PHASE_W-1:0] req0_phase;
    logic               req1_valid;
    logic               req1_ready;
    logic [PHASE_W-1:0] req1_phase;
    logic               cor_valid;
    logic [PHASE_W-1:0] cor_phase;
    logic [DATA_W-1:0]  cor_sin;
    logic [DATA_W-1:0]  cor_cos;
    logic               rsp0_valid;
    logic               rsp1_valid;
    logic [DATA_W-1:0]  rsp_sin;
    logic [DATA_W-1:0]  rsp_cos;
    logic               idle;

    modport slave (
        input  en, req0_valid, req0_phase, req1_valid, req1_phase, cor_sin, cor_cos,
        output req0_ready, req1_ready, cor_valid, cor_phase,
               rsp0_valid, rsp1_valid, rsp_sin, rsp_cos, idle
    );

    modport master (
        output en, req0_valid, req0_phase, req1_valid, req1_phase, cor_sin, cor_cos,
        input  req0_ready, req1_ready, cor_valid, cor_phase,
               rsp0_valid, rsp1_valid, rsp_sin, rsp_cos, idle
    );
endinterface

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin sharing of one pipelined CORDIC core between two phase requesters,
// with a requester-ID tag pipeline that steers each returning sin/cos result back to its issuer.
module cordic_arbiter #(
    parameter int PHASE_W = 32,
    parameter int DATA_W  = 32,
    parameter int LAT     = 16
) (
    input logic              CLK_50M,
    input logic              RST_N,
    cordic_arbiter_if.slave  bus
);
    logic           pri;
    logic           cor_id;
    logic           grant;
    logic [LAT-1:0] tag_valid;
    logic [LAT-1:0] tag_id;

    always_comb begin
        bus.req0_ready = RST_N && bus.en && bus.req0_valid && (!bus.req1_valid || !pri);
        bus.req1_ready = RST_N && bus.en && bus.req1_valid && (!bus.req0_valid || pri);
    end

    assign grant = bus.req0_ready || bus.req1_ready;

    // The cor_valid/cor_id register is the first tag stage; the LAT-deep shifter follows it,
    // so the last stage lines up with the core result LAT cycles after cor_valid.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            pri            <= 1'b0;
            bus.cor_valid  <= 1'b0;
            bus.cor_phase  <= '0;
            cor_id         <= 1'b0;
            tag_valid      <= '0;
            tag_id         <= '0;
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            bus.rsp_sin    <= '0;
            bus.rsp_cos    <= '0;
        end else begin
            if (grant) begin
                pri           <= bus.req0_ready;
                bus.cor_phase <= bus.req1_ready ? bus.req1_phase : bus.req0_phase;
            end
            bus.cor_valid  <= grant;
            cor_id         <= bus.req1_ready;
            tag_valid      <= (tag_valid << 1) | LAT'(bus.cor_valid);
            tag_id         <= (tag_id << 1) | LAT'(cor_id);
            bus.rsp0_valid <= tag_valid[LAT-1] && !tag_id[LAT-1];
            bus.rsp1_valid <= tag_valid[LAT-1] && tag_id[LAT-1];
            if (tag_valid[LAT-1]) begin
                bus.rsp_sin <= bus.cor_sin;
                bus.rsp_cos <= bus.cor_cos;
            end
        end
    end

    assign bus.idle = !(|tag_valid) && !bus.cor_valid && !bus.rsp0_valid && !bus.rsp1_valid;
endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: directed grant table plus hand-written multi-cycle sequences, with a
// fixed-latency core model and an issue-order scoreboard checking every response pulse.
module tb_cordic_arbiter;
    localparam int LAT = 16;

    typedef struct {
        logic        en, v0, v1;
        logic [31:0] p0, p1;
        logic        e0, e1;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] ph;
        int          due;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;
    int   pulses = 0;
    int   base;
    rec_t q[$];
    vec_t tbl[18];
    logic [31:0] cp[LAT];

    cordic_arbiter_if #(.PHASE_W(32), .DATA_W(32)) bus ();

    cordic_arbiter #(.PHASE_W(32), .DATA_W(32), .LAT(LAT)) dut (
        .CLK_50M(clk),
        .RST_N  (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sin_f(input logic [31:0] p);
        return p * 32'd3 + 32'd1;
    endfunction

    function automatic logic [31:0] cos_f(input logic [31:0] p);
        return ~p + 32'd7;
    endfunction

    // Core model: result for the phase presented in cycle N appears in cycle N+LAT, never reset.
    always @(posedge clk) begin
        cp[0] <= bus.cor_phase;
        for (int i = 1; i < LAT; i++) cp[i] <= cp[i-1];
    end
    assign bus.cor_sin = sin_f(cp[LAT-1]);
    assign bus.cor_cos = cos_f(cp[LAT-1]);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        rec_t e;
        if (!rst_n) q.delete();
        else begin
            if (q.size() > 0 && q[0].due < cyc) begin
                e = q.pop_front();
                chk("rsp_missing", 0, 1);
            end
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                pulses++;
                chk("rsp_exclusive", bus.rsp0_valid & bus.rsp1_valid, 0);
                if (q.size() == 0) chk("rsp_unexpected", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("rsp_id", bus.rsp1_valid, e.id);
                    chk("rsp_sin", bus.rsp_sin, sin_f(e.ph));
                    chk("rsp_cos", bus.rsp_cos, cos_f(e.ph));
                    chk("rsp_cycle", cyc, e.due);
                end
            end
            if (bus.req0_ready && bus.req1_ready) chk("one_grant", 1, 0);
            if (bus.req0_valid && bus.req0_ready) q.push_back('{1'b0, bus.req0_phase, cyc + LAT + 2});
            if (bus.req1_valid && bus.req1_ready) q.push_back('{1'b1, bus.req1_phase, cyc + LAT + 2});
        end
    end

    task automatic drain(input string name);
        for (int i = 0; i < 200 && !bus.idle; i++) @(negedge clk);
        @(negedge clk);
        chk(name, bus.idle, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1, 1, 1, 32'h1000, 32'h2000, 1, 0};
        tbl[1]  = '{1, 1, 1, 32'h1001, 32'h2001, 0, 1};
        tbl[2]  = '{1, 1, 1, 32'h1002, 32'h2002, 1, 0};
        tbl[3]  = '{1, 1, 1, 32'h1003, 32'h2003, 0, 1};
        tbl[4]  = '{1, 1, 1, 32'h1004, 32'h2004, 1, 0};
        tbl[5]  = '{1, 1, 1, 32'h1005, 32'h2005, 0, 1};
        tbl[6]  = '{1, 1, 1, 32'h1006, 32'h2006, 1, 0};
        tbl[7]  = '{1, 1, 1, 32'h1007, 32'h2007, 0, 1};
        tbl[8]  = '{0, 1, 1, 32'h1008, 32'h2008, 0, 0};
        tbl[9]  = '{1, 0, 1, 32'h1009, 32'h2009, 0, 1};
        tbl[10] = '{1, 1, 1, 32'h100a, 32'h200a, 1, 0};
        tbl[11] = '{1, 1, 0, 32'h100b, 32'h200b, 1, 0};
        tbl[12] = '{1, 1, 1, 32'h100c, 32'h200c, 0, 1};
        tbl[13] = '{1, 0, 0, 32'h100d, 32'h200d, 0, 0};
        tbl[14] = '{1, 0, 1, 32'h100e, 32'h200e, 0, 1};
        tbl[15] = '{1, 1, 1, 32'h100f, 32'h200f, 1, 0};
        tbl[16] = '{1, 0, 1, 32'h1010, 32'h2010, 0, 1};
        tbl[17] = '{1, 1, 1, 32'h1011, 32'h2011, 1, 0};

        bus.en = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_phase = 32'h0;
        bus.req1_phase = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready0", bus.req0_ready, 0);
        chk("reset_ready1", bus.req1_ready, 0);
        chk("reset_cor_valid", bus.cor_valid, 0);
        chk("reset_cor_phase", bus.cor_phase, 0);
        chk("reset_rsp0", bus.rsp0_valid, 0);
        chk("reset_rsp1", bus.rsp1_valid, 0);
        chk("reset_rsp_sin", bus.rsp_sin, 0);
        chk("reset_rsp_cos", bus.rsp_cos, 0);
        chk("reset_idle", bus.idle, 1);
        tick();
        rst_n = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        tick();
        bus.req0_valid = 1'b1;
        bus.req0_phase = 32'd60;
        @(negedge clk);
        chk("single_ready0", bus.req0_ready, 1);
        chk("single_ready1", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("single_cor_valid", bus.cor_valid, 1);
        chk("single_cor_phase", bus.cor_phase, 60);
        tick();
        @(negedge clk);
        chk("single_cor_valid_drop", bus.cor_valid, 0);
        chk("single_cor_phase_hold", bus.cor_phase, 60);
        drain("single_idle");
        chk("single_pulses", pulses, 1);

        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        base = pulses;
        foreach (tbl[i]) begin
            tick();
            bus.en = tbl[i].en;
            bus.req0_valid = tbl[i].v0;
            bus.req1_valid = tbl[i].v1;
            bus.req0_phase = tbl[i].p0;
            bus.req1_phase = tbl[i].p1;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready0", i), bus.req0_ready, tbl[i].e0);
            chk($sformatf("tbl%0d_ready1", i), bus.req1_ready, tbl[i].e1);
        end
        tick();
        bus.en = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        drain("tbl_idle");
        chk("tbl_pulses", pulses, base + 16);

        base = pulses;
        tick();
        for (int i = 0; i < 20; i++) begin
            bus.req1_valid = 1'b1;
            bus.req1_phase = 32'd300 + i;
            @(negedge clk);
            chk("b2b_ready1", bus.req1_ready, 1);
            if (i > 0) chk("b2b_busy", bus.idle, 0);
            tick();
        end
        bus.req1_valid = 1'b0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            chk("b2b_busy_tail", bus.idle, 0);
            tick();
        end
        @(negedge clk);
        chk("b2b_idle", bus.idle, 1);
        chk("b2b_pulses", pulses, base + 20);

        base = pulses;
        tick();
        bus.req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.req0_phase = 32'd400 + i;
            @(negedge clk);
            chk("en_ready0", bus.req0_ready, 1);
            tick();
        end
        bus.en = 1'b0;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        chk("en_off_ready0", bus.req0_ready, 0);
        chk("en_off_ready1", bus.req1_ready, 0);
        repeat (LAT + 4) tick();
        @(negedge clk);
        chk("en_off_pulses", pulses, base + 5);
        chk("en_off_idle", bus.idle, 1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.en = 1'b1;

        base = pulses;
        tick();
        bus.req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.req0_phase = 32'd500 + i;
            tick();
        end
        bus.req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_cor_valid", bus.cor_valid, 0);
        chk("midrst_idle", bus.idle, 1);
        chk("midrst_ready0", bus.req0_ready, 0);
        chk("midrst_ready1", bus.req1_ready, 0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_next_ready0", bus.req0_ready, 1);
        chk("midrst_next_ready1", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (LAT + 8) tick();
        @(negedge clk);
        chk("midrst_pulses", pulses, base + 1);
        chk("midrst_idle_end", bus.idle, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
